// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state constants for the HP0 slave memory.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_DATA = 2'd1;
    localparam w_state_t W_RESP = 2'd2;

    typedef logic [0:0] r_state_t;
    localparam r_state_t R_IDLE = 1'b0;
    localparam r_state_t R_DATA = 1'b1;

    // Only FIXED and INCR are served; WRAP and the reserved code answer SLVERR.
    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_hp0_slave_mem_if.sv
// AXI4 bus bundle between the DMA master and the slave memory responder.
interface axi_hp0_slave_mem_if #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTES-1:0]      wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_slave_ram.sv
// Word-addressed RAM with byte-enable write port and registered, read-first read port.
module axi_slave_ram #(
    parameter int MEM_AW     = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [MEM_AW-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [MEM_AW-1:0]       raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_hp0_slave_mem.sv
// AXI4 slave memory responder for the TLK2711 DMA loopback; independent read and write FSMs.
module axi_hp0_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 12
) (
    input  logic                clk,
    input  logic                rstn,
    axi_hp0_slave_mem_if.slave  s_axi
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [MEM_AW-1:0]     w_index;
    logic [7:0]            w_len, w_beat;
    logic                  w_incr, w_err;

    r_state_t              r_state;
    logic [MEM_AW-1:0]     r_index, r_next;
    logic [7:0]            r_len, r_beat;
    logic                  r_incr, r_err;

    logic                  w_fire, w_at_len;
    logic [BYTES-1:0]      ram_we;
    logic                  ram_re;
    logic [MEM_AW-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic unused_ok;
    assign unused_ok = ^{s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB+MEM_AW], s_axi.awaddr[ADDR_LSB-1:0],
                         s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB+MEM_AW], s_axi.araddr[ADDR_LSB-1:0],
                         s_axi.awsize, s_axi.arsize};

    assign w_fire   = (w_state == W_DATA) && s_axi.wvalid && s_axi.wready;
    assign w_at_len = (w_beat == w_len);
    assign ram_we   = (w_fire && !w_err) ? s_axi.wstrb : '0;
    assign r_next   = r_incr ? r_index + 1'b1 : r_index;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = r_next;
        if ((r_state == R_IDLE) && s_axi.arvalid && s_axi.arready) begin
            ram_re    = 1'b1;
            ram_raddr = s_axi.araddr[ADDR_LSB +: MEM_AW];
        end else if ((r_state == R_DATA) && s_axi.rvalid && s_axi.rready && !s_axi.rlast) begin
            ram_re    = 1'b1;
        end
    end

    axi_slave_ram #(.MEM_AW(MEM_AW), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk(clk), .rstn(rstn),
        .we(ram_we), .waddr(w_index), .wdata(s_axi.wdata),
        .re(ram_re), .raddr(ram_raddr), .rdata(ram_rdata)
    );

    // Error bursts still handshake every beat but never expose memory contents.
    assign s_axi.rdata = r_err ? '0 : ram_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state       <= W_IDLE;
            w_id          <= '0;
            w_index       <= '0;
            w_len         <= '0;
            w_beat        <= '0;
            w_incr        <= 1'b0;
            w_err         <= 1'b0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bid     <= '0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: if (s_axi.awvalid && s_axi.awready) begin
                    w_id          <= s_axi.awid;
                    w_index       <= s_axi.awaddr[ADDR_LSB +: MEM_AW];
                    w_len         <= s_axi.awlen;
                    w_beat        <= '0;
                    w_incr        <= (s_axi.awburst == BURST_INCR);
                    w_err         <= !burst_ok(s_axi.awburst);
                    s_axi.awready <= 1'b0;
                    s_axi.wready  <= 1'b1;
                    w_state       <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    // A burst closes on wlast or on beat len, whichever comes first.
                    if (s_axi.wlast || w_at_len) begin
                        s_axi.wready <= 1'b0;
                        s_axi.bvalid <= 1'b1;
                        s_axi.bid    <= w_id;
                        s_axi.bresp  <= (w_err || (s_axi.wlast != w_at_len)) ? RESP_SLVERR : RESP_OKAY;
                        w_state      <= W_RESP;
                    end else begin
                        w_beat <= w_beat + 8'd1;
                        if (w_incr) w_index <= w_index + 1'b1;
                    end
                end
                W_RESP: if (s_axi.bready) begin
                    s_axi.bvalid  <= 1'b0;
                    s_axi.awready <= 1'b1;
                    w_state       <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= R_IDLE;
            r_index       <= '0;
            r_len         <= '0;
            r_beat        <= '0;
            r_incr        <= 1'b0;
            r_err         <= 1'b0;
            s_axi.arready <= 1'b1;
            s_axi.rvalid  <= 1'b0;
            s_axi.rlast   <= 1'b0;
            s_axi.rid     <= '0;
            s_axi.rresp   <= RESP_OKAY;
        end else if (r_state == R_IDLE) begin
            if (s_axi.arvalid && s_axi.arready) begin
                r_index       <= s_axi.araddr[ADDR_LSB +: MEM_AW];
                r_len         <= s_axi.arlen;
                r_beat        <= '0;
                r_incr        <= (s_axi.arburst == BURST_INCR);
                r_err         <= !burst_ok(s_axi.arburst);
                s_axi.arready <= 1'b0;
                s_axi.rvalid  <= 1'b1;
                s_axi.rlast   <= (s_axi.arlen == 8'd0);
                s_axi.rid     <= s_axi.arid;
                s_axi.rresp   <= burst_ok(s_axi.arburst) ? RESP_OKAY : RESP_SLVERR;
                r_state       <= R_DATA;
            end
        end else if (s_axi.rvalid && s_axi.rready) begin
            if (s_axi.rlast) begin
                s_axi.rvalid  <= 1'b0;
                s_axi.rlast   <= 1'b0;
                s_axi.arready <= 1'b1;
                r_state       <= R_IDLE;
            end else begin
                r_index     <= r_next;
                r_beat      <= r_beat + 8'd1;
                s_axi.rlast <= ((r_beat + 8'd1) == r_len);
            end
        end
    end

endmodule
